// File: rtl/lx45_clock_monitor_pkg.sv
// -----------------------------------------------------------------------------
// lx45_clock_monitor_pkg
// Shared definitions for the lx45 clock monitor: FSM state encoding and the
// default window / stuck-limit constants. The status register map imports
// this package so that firmware-visible state codes stay in step with the RTL.
// -----------------------------------------------------------------------------
package lx45_clock_monitor_pkg;

  // Measurement FSM state encoding (also reported through the status map).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATE   = 2'd1,
    ST_REPORT = 2'd2
  } mon_state_e;

  // Defaults: 1 ms gate at 50 MHz, 16-bit count, 64-cycle stuck threshold.
  localparam int unsigned LX45_GATE_CYCLES_DEF = 50000;
  localparam int unsigned LX45_COUNT_W_DEF     = 16;
  localparam int unsigned LX45_STUCK_LIMIT_DEF = 64;

  // Internal counter widths, sized to the largest legal parameter values.
  localparam int unsigned LX45_GATE_W = 24;
  localparam int unsigned LX45_IDLE_W = 16;

endpackage

// File: rtl/lx45_clock_monitor_if.sv
// -----------------------------------------------------------------------------
// lx45_clock_monitor_if
// Signal bundle between the clock monitor and its user (status logic / bench).
//   mon_in      : monitored clock-like signal, asynchronous to clk
//   enable      : level-sensitive measurement enable
//   count       : rising edges counted in the last completed window
//   count_valid : one-cycle pulse when count/overflow update
//   overflow    : last completed window saturated the counter
//   stuck       : no mon_in edge seen for STUCK_LIMIT cycles
// Modports: master drives mon_in/enable, slave (the monitor) drives results.
// -----------------------------------------------------------------------------
interface lx45_clock_monitor_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               mon_in;
  logic               enable;
  logic [COUNT_W-1:0] count;
  logic               count_valid;
  logic               overflow;
  logic               stuck;

  modport master (
    output mon_in, enable,
    input  count, count_valid, overflow, stuck
  );

  modport slave (
    input  mon_in, enable,
    output count, count_valid, overflow, stuck
  );
endinterface

// File: rtl/lx45_sync_edge.sv
// -----------------------------------------------------------------------------
// lx45_sync_edge
// Two-flop synchronizer plus one history flop for an asynchronous input, with
// rising-edge and any-edge detect. Reusable for buttons, PS/2 lines, etc.
//   clk     : sampling clock
//   reset   : synchronous, active-high
//   i_async : asynchronous input
//   o_rise  : one-cycle pulse on a synchronized 0->1 transition
//   o_edge  : one-cycle pulse on any synchronized transition
// -----------------------------------------------------------------------------
module lx45_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // NOTE: non-blocking assignments let every flop sample the pre-edge value of
  // its neighbour, which is what makes this a shift chain rather than a wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // r_s1 may be metastable; detection uses only the settled r_s2/r_s3 pair.
  assign o_rise = r_s2 & ~r_s3;
  assign o_edge = r_s2 ^ r_s3;

endmodule

// File: rtl/lx45_clock_monitor.sv
// -----------------------------------------------------------------------------
// lx45_clock_monitor
// Frequency meter and stuck-clock detector running in the clk50 domain.
// Counts rising edges of bus.mon_in over a GATE_CYCLES window, reports the
// count (with saturation flag) once per window, and flags a stopped clock.
//   clk   : clk50 domain clock
//   reset : synchronous, active-high
//   bus   : lx45_clock_monitor_if slave (mon_in/enable in, results out)
// -----------------------------------------------------------------------------
module lx45_clock_monitor
  import lx45_clock_monitor_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = LX45_GATE_CYCLES_DEF,
  parameter int unsigned COUNT_W     = LX45_COUNT_W_DEF,
  parameter int unsigned STUCK_LIMIT = LX45_STUCK_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  lx45_clock_monitor_if.slave  bus
);

  localparam logic [LX45_GATE_W-1:0] GATE_LAST = LX45_GATE_W'(GATE_CYCLES - 1);
  localparam logic [LX45_IDLE_W-1:0] STUCK_LIM = LX45_IDLE_W'(STUCK_LIMIT);
  localparam logic [COUNT_W-1:0]     EDGE_MAX  = '1;
  localparam logic [LX45_IDLE_W-1:0] IDLE_MAX  = '1;

  mon_state_e             r_state;
  mon_state_e             w_state_nxt;
  logic [LX45_GATE_W-1:0] r_gate_cnt;
  logic [COUNT_W-1:0]     r_edge_cnt;
  logic                   r_sat;
  logic [COUNT_W-1:0]     r_count;
  logic                   r_overflow;
  logic                   r_count_valid;
  logic [LX45_IDLE_W-1:0] r_idle_cnt;
  logic [LX45_IDLE_W-1:0] w_idle_nxt;
  logic                   r_stuck;
  logic                   w_rise;
  logic                   w_edge;
  logic                   w_gate_last;

  lx45_sync_edge u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.mon_in),
    .o_rise  (w_rise),
    .o_edge  (w_edge)
  );

  assign w_gate_last = (r_gate_cnt == GATE_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path through the
  // case/if tree leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (bus.enable) w_state_nxt = ST_GATE;
      ST_GATE: begin
        // Dropping enable aborts the window; it takes priority over gate end.
        if (!bus.enable)      w_state_nxt = ST_IDLE;
        else if (w_gate_last) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: w_state_nxt = bus.enable ? ST_GATE : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Gate/edge counters and the reported results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate_cnt    <= '0;
      r_edge_cnt    <= '0;
      r_sat         <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_count_valid <= 1'b0;
    end else begin
      r_count_valid <= 1'b0;
      if (r_state == ST_GATE && bus.enable) begin
        r_gate_cnt <= r_gate_cnt + LX45_GATE_W'(1);
        // A rise in the last gate cycle still lands here before REPORT.
        if (w_rise) begin
          if (r_edge_cnt == EDGE_MAX) r_sat      <= 1'b1;
          else                        r_edge_cnt <= r_edge_cnt + COUNT_W'(1);
        end
      end else begin
        // IDLE, REPORT (dead cycle) and an aborted GATE all restart from zero.
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
        r_sat      <= 1'b0;
        if (r_state == ST_REPORT) begin
          r_count       <= r_edge_cnt;
          r_overflow    <= r_sat;
          r_count_valid <= 1'b1;
        end
      end
    end
  end

  // Cycles since the last mon_in edge while enabled, saturating.
  always_comb begin
    w_idle_nxt = r_idle_cnt;
    if (w_edge || !bus.enable)   w_idle_nxt = '0;
    else if (r_idle_cnt != IDLE_MAX) w_idle_nxt = r_idle_cnt + LX45_IDLE_W'(1);
  end

  // stuck follows the updated idle count so it drops the cycle after an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_cnt <= '0;
      r_stuck    <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_nxt;
      r_stuck    <= (w_idle_nxt >= STUCK_LIM);
    end
  end

  assign bus.count       = r_count;
  assign bus.count_valid = r_count_valid;
  assign bus.overflow    = r_overflow;
  assign bus.stuck       = r_stuck;

endmodule

// File: tb/tb_lx45_clock_monitor.sv
// -----------------------------------------------------------------------------
// tb_lx45_clock_monitor
// Two monitors share one stimulus: a 16-bit counter (never saturates here) and
// a 4-bit counter (saturates at 15). The reference model records every sampled
// mon_in value, derives window boundaries from the enable history, and counts
// rises per window from the recorded samples; results are queued and popped by
// a negedge monitor whenever count_valid is seen.
// -----------------------------------------------------------------------------
module tb_lx45_clock_monitor;

  localparam int G     = 100;
  localparam int L     = 64;
  localparam int W_A   = 16;
  localparam int W_B   = 4;
  localparam int MAXC  = 20000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic mon   = 1'b0;
  logic en    = 1'b0;
  int   half  = 0;   // mon_in half-period in clk cycles; 0 holds the level
  int   ph    = 0;

  always #5 clk = ~clk;

  lx45_clock_monitor_if #(.COUNT_W(W_A)) bus_a ();
  lx45_clock_monitor_if #(.COUNT_W(W_B)) bus_b ();

  assign bus_a.mon_in = mon;
  assign bus_a.enable = en;
  assign bus_b.mon_in = mon;
  assign bus_b.enable = en;

  lx45_clock_monitor #(.GATE_CYCLES(G), .COUNT_W(W_A), .STUCK_LIMIT(L)) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );
  lx45_clock_monitor #(.GATE_CYCLES(G), .COUNT_W(W_B), .STUCK_LIMIT(L)) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );

  // ---------------- reference model ----------------
  typedef struct { int due; int n; } win_t;
  typedef enum { W_IDLE, W_OPEN, W_REPORT } win_e;

  bit   samp [0:MAXC];    // samp[k] = mon_in as seen by posedge k
  int   cyc = 3;
  win_e win = W_IDLE;
  int   start = 0;
  int   last_break = 3;
  bit   exp_stuck = 1'b0;
  bit   rst_seen = 1'b0;
  win_t q_a[$];
  win_t q_b[$];

  int n_cmp = 0;
  int n_bad = 0;

  // A rise/edge sampled at posedges k-1 -> k is acted upon at posedge k+2.
  function automatic int rises_in(int s);
    int n = 0;
    for (int t = s + 1; t <= s + G; t++)
      if (samp[t-2] && !samp[t-3]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    win_t e;
    cyc++;
    samp[cyc] = mon;
    rst_seen  = reset;
    if (reset) begin
      // Synchronizer flops clear, so the recent history reads as zeros.
      samp[cyc] = 1'b0; samp[cyc-1] = 1'b0; samp[cyc-2] = 1'b0;
      win = W_IDLE;
      last_break = cyc;
      q_a.delete();
      q_b.delete();
    end else begin
      if ((samp[cyc-2] != samp[cyc-3]) || !en) last_break = cyc;
      case (win)
        W_IDLE: if (en) begin win = W_OPEN; start = cyc; end
        W_OPEN: begin
          if (!en) win = W_IDLE;
          else if (cyc == start + G) begin
            e.n   = rises_in(start);
            e.due = cyc + 1;
            q_a.push_back(e);
            q_b.push_back(e);
            win = W_REPORT;
          end
        end
        W_REPORT: begin
          if (en) begin win = W_OPEN; start = cyc; end
          else win = W_IDLE;
        end
      endcase
    end
    exp_stuck = (cyc - last_break) >= L;
  end

  // ---------------- checking ----------------
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  int hold_cnt [2] = '{0, 0};
  bit hold_ovf [2] = '{1'b0, 1'b0};
  int max_cnt  [2] = '{(1 << W_A) - 1, (1 << W_B) - 1};

  task automatic mon_port(int p, string nm, logic v, logic [31:0] cnt, logic ovf, logic stk);
    win_t e;
    int   qs;
    qs = (p == 0) ? q_a.size() : q_b.size();
    if (rst_seen) begin
      hold_cnt[p] = 0;
      hold_ovf[p] = 1'b0;
    end
    if (v === 1'b1) begin
      if (qs == 0) check({nm, "_unexpected_valid"}, 32'(v), 0);
      else begin
        e = (p == 0) ? q_a.pop_front() : q_b.pop_front();
        check({nm, "_valid_cycle"}, cyc, e.due);
        hold_cnt[p] = (e.n > max_cnt[p]) ? max_cnt[p] : e.n;
        hold_ovf[p] = (e.n > max_cnt[p]);
      end
    end else if (qs > 0) begin
      e = (p == 0) ? q_a[0] : q_b[0];
      if (e.due < cyc) begin
        check({nm, "_missing_valid"}, 32'(v), 1);
        if (p == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
      end
    end
    check({nm, "_count"}, cnt, hold_cnt[p]);
    check({nm, "_overflow"}, 32'(ovf), 32'(hold_ovf[p]));
    check({nm, "_stuck"}, 32'(stk), 32'(exp_stuck));
  endtask

  always @(negedge clk) begin
    if (cyc > 3) begin
      mon_port(0, "a", bus_a.count_valid, 32'(bus_a.count), bus_a.overflow, bus_a.stuck);
      mon_port(1, "b", bus_b.count_valid, 32'(bus_b.count), bus_b.overflow, bus_b.stuck);
    end
  end

  // ---------------- stimulus ----------------
  always begin
    @(posedge clk);
    #1;
    if (half > 0) begin
      ph++;
      if (ph >= half) begin
        mon = ~mon;
        ph  = 0;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the model is at gate position pos; bounded.
  task automatic wait_gate_pos(int pos);
    bit found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      if (win == W_OPEN && cyc == start + pos) found = 1'b1;
    end
    check("gate_pos_reached", 32'(found), 1);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mon = 1'b0; half = 0;
    step(3);
    reset = 1'b0;
    step(2);

    // 25 MHz: 50 per window on the wide counter, saturated on the narrow one.
    half = 1; en = 1'b1;
    step(3 * 101 + 5);

    // Random frequencies.
    for (int k = 0; k < 4; k++) begin
      half = $urandom_range(1, 6);
      step(2 * 101);
    end

    // 6.25 MHz, then period 16 (narrow counter recovers from overflow).
    half = 4; step(250);
    half = 8; step(250);

    // Stop the clock low: stuck after L quiet cycles, then restart.
    half = 0; mon = 1'b0;
    step(100);
    half = 1;
    step(30);

    // Abort mid-window, then re-enable for full windows.
    wait_gate_pos(50);
    en = 1'b0;
    step(10);
    en = 1'b1;
    step(250);

    // One-cycle reset in the middle of a window.
    wait_gate_pos(30);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step(250);

    // Random enable / frequency mix.
    for (int k = 0; k < 20; k++) begin
      en   = 1'($urandom_range(0, 3) != 0);
      half = $urandom_range(0, 5);
      step($urandom_range(5, 150));
    end

    en = 1'b1; half = 2;
    step(250);
    en = 1'b0;
    step(10);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
